// File: rtl/regfile_pkg.sv
// Shared widths and constants for the renaming register file.
// The no-producer tag sits just past the highest valid ROB tag (0..31).
package regfile_pkg;
   localparam int   XLEN           = 32;
   localparam int   AW             = 5;
   localparam int   NREG_DEF       = 32;
   localparam int   TW_DEF         = 6;
   localparam int   ROB_DEPTH      = 32;
   localparam int   ENTRY_NULL_IDX = ROB_DEPTH;
   localparam logic TRUE           = 1'b1;
   localparam logic FALSE          = 1'b0;
endpackage

// File: rtl/regfile.sv
// Architectural register file with rename tags and CDB/commit read forwarding.
// Reads are combinational and see registered state. Updates happen on posedge clk.
module regfile
   import regfile_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int TW   = TW_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            rollback,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic [XLEN-1:0] Vj,
   output logic [XLEN-1:0] Vk,
   output logic [TW-1:0]   Qj,
   output logic [TW-1:0]   Qk,
   input  logic            issue_valid,
   input  logic [AW-1:0]   issue_rd,
   input  logic [TW-1:0]   issue_entry,
   input  logic            alu_broadcast,
   input  logic [TW-1:0]   alu_entry,
   input  logic [XLEN-1:0] alu_result,
   input  logic            lsb_broadcast,
   input  logic [TW-1:0]   lsb_entry,
   input  logic [XLEN-1:0] lsb_result,
   input  logic            rob_commit,
   input  logic [AW-1:0]   rob_rd,
   input  logic [TW-1:0]   rob_entry,
   input  logic [XLEN-1:0] rob_result
);
   localparam logic [TW-1:0] ENTRY_NULL = TW'(ENTRY_NULL_IDX);

   logic [XLEN-1:0] value_q [NREG];
   logic [XLEN-1:0] value_d [NREG];
   logic [TW-1:0]   tag_q   [NREG];
   logic [TW-1:0]   tag_d   [NREG];

   // Returns {V, Q}; a producer finishing this cycle resolves to its result (rob > alu > lsb).
   function automatic logic [XLEN+TW-1:0] fwd(input logic [AW-1:0]   addr,
                                              input logic [XLEN-1:0] val,
                                              input logic [TW-1:0]   tag);
      logic [XLEN+TW-1:0] r;
      r = {val, tag};
      if (addr == '0)
         r = {{XLEN{1'b0}}, ENTRY_NULL};
      else if (tag == ENTRY_NULL)
         r = {val, ENTRY_NULL};
      else if (rob_commit && rob_entry == tag)
         r = {rob_result, ENTRY_NULL};
      else if (alu_broadcast && alu_entry == tag)
         r = {alu_result, ENTRY_NULL};
      else if (lsb_broadcast && lsb_entry == tag)
         r = {lsb_result, ENTRY_NULL};
      return r;
   endfunction

   assign {Vj, Qj} = fwd(rs1_addr, value_q[rs1_addr], tag_q[rs1_addr]);
   assign {Vk, Qk} = fwd(rs2_addr, value_q[rs2_addr], tag_q[rs2_addr]);

   always_comb begin
      value_d = value_q;
      tag_d   = tag_q;
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            value_d[i] = '0;
            tag_d[i]   = ENTRY_NULL;
         end
      end else if (rollback) begin
         // Flush drops every in-flight rename, but the retiring value is still architectural.
         if (rob_commit && rob_rd != '0) value_d[rob_rd] = rob_result;
         for (int i = 0; i < NREG; i++) tag_d[i] = ENTRY_NULL;
      end else if (rdy) begin
         if (rob_commit && rob_rd != '0) begin
            value_d[rob_rd] = rob_result;
            if (tag_q[rob_rd] == rob_entry) tag_d[rob_rd] = ENTRY_NULL;
         end
         // Applied after commit so a same-cycle rename of the same register wins.
         if (issue_valid && issue_rd != '0) tag_d[issue_rd] = issue_entry;
      end
   end

   always_ff @(posedge clk) begin
      value_q <= value_d;
      tag_q   <= tag_d;
   end
endmodule

// File: tb/tb_regfile.sv
// Directed and randomized checks of regfile against an array-based reference model.
module tb_regfile;
   logic        clk = 1'b0;
   logic        rst, rdy, rollback;
   logic [4:0]  rs1_addr, rs2_addr;
   logic [31:0] Vj, Vk;
   logic [5:0]  Qj, Qk;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic [5:0]  issue_entry;
   logic        alu_broadcast, lsb_broadcast, rob_commit;
   logic [5:0]  alu_entry, lsb_entry, rob_entry;
   logic [31:0] alu_result, lsb_result, rob_result;
   logic [4:0]  rob_rd;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] mval [32];
   logic [5:0]  mtag [32];

   always #5 clk = ~clk;

   regfile dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_entry(issue_entry),
      .alu_broadcast(alu_broadcast), .alu_entry(alu_entry), .alu_result(alu_result),
      .lsb_broadcast(lsb_broadcast), .lsb_entry(lsb_entry), .lsb_result(lsb_result),
      .rob_commit(rob_commit), .rob_rd(rob_rd), .rob_entry(rob_entry), .rob_result(rob_result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 0; rdy = 1; rollback = 0;
      issue_valid = 0; issue_rd = 0; issue_entry = 0;
      alu_broadcast = 0; alu_entry = 0; alu_result = 0;
      lsb_broadcast = 0; lsb_entry = 0; lsb_result = 0;
      rob_commit = 0; rob_rd = 0; rob_entry = 0; rob_result = 0;
   endtask

   // What a reader of register r must see this cycle.
   task automatic ref_read(input logic [4:0] r, output logic [31:0] v, output logic [5:0] q);
      logic [5:0] t;
      t = mtag[r];
      v = mval[r]; q = t;
      if (r == 0) begin v = 0; q = 32; end
      else if (t == 32) q = 32;
      else if (rob_commit && rob_entry == t) begin v = rob_result; q = 32; end
      else if (alu_broadcast && alu_entry == t) begin v = alu_result; q = 32; end
      else if (lsb_broadcast && lsb_entry == t) begin v = lsb_result; q = 32; end
   endtask

   task automatic model_check();
      logic [31:0] v; logic [5:0] q;
      ref_read(rs1_addr, v, q);
      chk("rs1_V", Vj, v); chk("rs1_Q", {26'd0, Qj}, {26'd0, q});
      ref_read(rs2_addr, v, q);
      chk("rs2_V", Vk, v); chk("rs2_Q", {26'd0, Qk}, {26'd0, q});
   endtask

   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < 32; i++) begin mval[i] = 0; mtag[i] = 32; end
      end else if (rollback) begin
         if (rob_commit && rob_rd != 0) mval[rob_rd] = rob_result;
         for (int i = 0; i < 32; i++) mtag[i] = 32;
      end else if (rdy) begin
         if (rob_commit && rob_rd != 0) begin
            mval[rob_rd] = rob_result;
            if (mtag[rob_rd] == rob_entry) mtag[rob_rd] = 32;
         end
         if (issue_valid && issue_rd != 0) mtag[issue_rd] = issue_entry;
      end
   endtask

   // Check reads against the model, clock once, advance the model, return to mid-cycle idle.
   task automatic step();
      #1 model_check();
      @(posedge clk);
      model_update();
      @(negedge clk);
      idle();
   endtask

   initial begin
      idle(); rs1_addr = 0; rs2_addr = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin mval[i] = 0; mtag[i] = 32; end
      idle();

      // reset state
      rs1_addr = 5; rs2_addr = 0; #1;
      chk("rst_Vj", Vj, 0); chk("rst_Qj", {26'd0, Qj}, 32);
      chk("rst_Vk", Vk, 0); chk("rst_Qk", {26'd0, Qk}, 32);
      step();

      // rename then forward from alu in the same cycle
      issue_valid = 1; issue_rd = 3; issue_entry = 7; step();
      rs1_addr = 3; #1 chk("ren_Q", {26'd0, Qj}, 7);
      alu_broadcast = 1; alu_entry = 7; alu_result = 32'h55;
      #1 chk("alu_fwd_V", Vj, 32'h55); chk("alu_fwd_Q", {26'd0, Qj}, 32);
      step();

      // older commit must not clear a younger rename
      issue_valid = 1; issue_rd = 4; issue_entry = 2; step();
      issue_valid = 1; issue_rd = 4; issue_entry = 9; step();
      rob_commit = 1; rob_rd = 4; rob_entry = 2; rob_result = 32'h10; step();
      rs1_addr = 4; #1 chk("young_V", Vj, 32'h10); chk("young_Q", {26'd0, Qj}, 9);
      step();

      // same-cycle issue and matching commit
      issue_valid = 1; issue_rd = 6; issue_entry = 12; step();
      issue_valid = 1; issue_rd = 6; issue_entry = 12;
      rob_commit = 1; rob_rd = 6; rob_entry = 12; rob_result = 32'hAB; step();
      rs2_addr = 6; #1 chk("iss_cmt_V", Vk, 32'hAB); chk("iss_cmt_Q", {26'd0, Qk}, 12);
      step();

      // rollback with a concurrent commit
      for (int i = 1; i <= 5; i++) begin
         issue_valid = 1; issue_rd = 5'(i); issue_entry = 6'(i); step();
      end
      rollback = 1; rob_commit = 1; rob_rd = 1; rob_entry = 1; rob_result = 32'h77;
      issue_valid = 1; issue_rd = 2; issue_entry = 20; step();
      rs1_addr = 1; rs2_addr = 2;
      #1 chk("rb_V1", Vj, 32'h77); chk("rb_Q1", {26'd0, Qj}, 32); chk("rb_Q2", {26'd0, Qk}, 32);
      step();

      // x0 writes ignored; rdy low holds state
      issue_valid = 1; issue_rd = 0; issue_entry = 3;
      rob_commit = 1; rob_rd = 0; rob_entry = 3; rob_result = 32'hFF; step();
      rs1_addr = 0; #1 chk("x0_V", Vj, 0); chk("x0_Q", {26'd0, Qj}, 32);
      rdy = 0; issue_valid = 1; issue_rd = 8; issue_entry = 20; step();
      rs1_addr = 8; #1 chk("hold_Q", {26'd0, Qj}, 32);
      step();

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         rst           = ($urandom_range(99) == 0);
         rdy           = ($urandom_range(9) != 0);
         rollback      = ($urandom_range(29) == 0);
         rs1_addr      = 5'($urandom);
         rs2_addr      = 5'($urandom);
         issue_valid   = ($urandom_range(2) != 0);
         issue_rd      = 5'($urandom);
         issue_entry   = 6'($urandom_range(31));
         alu_broadcast = $urandom_range(1) == 1;
         alu_entry     = 6'($urandom_range(31));
         alu_result    = $urandom;
         lsb_broadcast = $urandom_range(1) == 1;
         lsb_entry     = 6'($urandom_range(31));
         lsb_result    = $urandom;
         rob_commit    = $urandom_range(1) == 1;
         rob_rd        = 5'($urandom);
         rob_entry     = ($urandom_range(1) == 1) ? mtag[rob_rd] : 6'($urandom_range(31));
         rob_result    = $urandom;
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
